fma_operand_unpack: RTL and testbench
=====================================

FMA_OPERAND_UNPACK -- requirements
Module: fma_operand_unpack

Interface
REQ-001 SHALL have parameter PARM_EXP, default 8, exponent width.
REQ-002 SHALL have parameter PARM_MANT, default 23, stored-fraction width.
REQ-003 SHALL have parameter PARM_RM, default 3, rounding-mode width.
REQ-004 SHALL have port clk  input  1  the single clock, all state on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port A_i, B_i, C_i  input  PARM_EXP+PARM_MANT+1 each  IEEE-754 operands, result = A + B*C.
REQ-007 SHALL have port Negate_i  input  1  product subtracted (A - B*C) when 1.
REQ-008 SHALL have port Rounding_mode_i  input  PARM_RM  rounding mode, carried with the operands.
REQ-009 SHALL have port In_valid_i / In_ready_o  input / output  1  input handshake.
REQ-010 SHALL have port Out_valid_o / Out_ready_i  output / input  1  output handshake.
REQ-011 SHALL have port X_Sign_o, X_Exp_raw_o, X_Mant_o  output  1, PARM_EXP, PARM_MANT+1, for X in {A,B,C}  sign, raw exponent field, fraction with hidden bit.
REQ-012 SHALL have port X_Exp_eff_o  output  PARM_EXP  effective exponent, where raw 0 maps to 1.
REQ-013 SHALL have port X_DeN_o, X_Zero_o, X_Inf_o, X_NaN_o, X_SNaN_o  output  1 each  class flags, for X in {A,B,C}.
REQ-014 SHALL have port Sub_Sign_o  output  1  effective subtraction: A_sign ^ B_sign ^ C_sign ^ Negate_i.
REQ-015 SHALL have port Rounding_mode_o  output  PARM_RM  mode aligned with the outputs.

Function
REQ-016 SHALL be a 2-stage pipeline:
- S1 registers raw inputs on an input handshake (In_valid_i & In_ready_o).
- S2 registers the decoded fields and flags.
- Latency: exactly 2 cycles from input handshake to Out_valid_o with no stall.
REQ-017 SHALL hold a valid bit per stage (s1_v, s2_v); Out_valid_o = s2_v.
REQ-018 SHALL advance S2 when ~s2_v | Out_ready_i.
REQ-019 SHALL advance S1 into S2 when s1_v & S2-advance.
REQ-020 SHALL drive In_ready_o = ~s1_v | (S1 advances into S2), combinational, with no bubble under continuous flow.
REQ-021 SHALL sustain 1 transaction/cycle when Out_ready_i is held high.
REQ-022 SHALL, when Out_valid_o=1 & Out_ready_i=0, hold every S2 output stable and accept no data past S1.
REQ-023 SHALL load S2 in the same cycle it releases an item (simultaneous output and input handshakes), with no loss or duplication.
REQ-024 SHALL clear a stage's valid bit when it empties with no new data, leaving its data registers unchanged.
REQ-025 SHALL decode each operand X as follows (e = exponent field, f = fraction field):
- Zero = (e==0)&(f==0)
- DeN = (e==0)&(f!=0)
- Inf = (e==all1)&(f==0)
- NaN = (e==all1)&(f!=0)
- SNaN = NaN & ~f[PARM_MANT-1]
REQ-026 SHALL form X_Mant_o = {e!=0, f}: the hidden bit is 0 for zero/denormal and 1 otherwise, including Inf/NaN.
REQ-027 SHALL pass X_Exp_raw_o = e unmodified and set X_Exp_eff_o = (e==0) ? 1 : e.
REQ-028 SHALL assert exactly one of {Zero, DeN, Inf, NaN} per operand, or none for normal numbers.
REQ-029 SHALL carry Rounding_mode_o unchanged, including reserved encodings above 3'b100.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear s1_v, s2_v and all S1/S2 data registers to 0.
REQ-031 SHALL, one cycle after rst, present Out_valid_o=0, In_ready_o=1 and all data/flag outputs 0.
REQ-032 SHALL, when rst is asserted mid-operation, discard in-flight items; an input handshake in the reset cycle is ignored.
REQ-033 SHALL give rst priority over every handshake in the same cycle.

Verification
REQ-034 SHALL pass this scenario: A=0x3F800000, B=0x40000000, C=0xC0400000, Negate=0, Out_ready=1 -> 2 cycles later:
- A_Exp_raw=0x7F, A_Mant=0x800000
- B_Exp_raw=0x80
- C_Sign=1, C_Mant=0xC00000
- Sub_Sign=1
- all flags 0
REQ-035 SHALL pass this scenario: A=0x00000001, B=0x80000000, C=0x7F800000 ->
- A_DeN=1, A_Mant=0x000001, A_Exp_eff=1, A_Exp_raw=0
- B_Zero=1, B_Sign=1
- C_Inf=1, C_Mant=0x800000
REQ-036 SHALL pass this scenario: A=0x7FC00000, B=0x7F800001 -> A_NaN=1, A_SNaN=0; B_NaN=1, B_SNaN=1.
REQ-037 SHALL pass this scenario: 4 back-to-back inputs, Out_ready=0 for cycles 2-6 ->
- In_ready falls after 2 items are accepted.
- S2 outputs are held stable.
- After Out_ready rises, all 4 items emerge in order, 1/cycle.
REQ-038 SHALL pass this scenario: 2 items in flight, rst pulsed 1 cycle -> next cycle Out_valid=0, In_ready=1, outputs 0, and neither item appears afterwards.

Source files
------------

// File: rtl/fma_operand_unpack.sv
// ============================================================================
// Module   : fma_operand_unpack
// Brief    : Two-stage valid/ready pipeline that registers three IEEE-754
//            FMA operands and decodes their sign, exponent, mantissa and class.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fma_operand_unpack #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_RM   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PARM_EXP+PARM_MANT:0]   A_i,
    input  logic [PARM_EXP+PARM_MANT:0]   B_i,
    input  logic [PARM_EXP+PARM_MANT:0]   C_i,
    input  logic                          Negate_i,
    input  logic [PARM_RM-1:0]            Rounding_mode_i,
    input  logic                          In_valid_i,
    output logic                          In_ready_o,
    output logic                          Out_valid_o,
    input  logic                          Out_ready_i,
    output logic                          A_Sign_o,
    output logic [PARM_EXP-1:0]           A_Exp_raw_o,
    output logic [PARM_EXP-1:0]           A_Exp_eff_o,
    output logic [PARM_MANT:0]            A_Mant_o,
    output logic                          A_DeN_o,
    output logic                          A_Zero_o,
    output logic                          A_Inf_o,
    output logic                          A_NaN_o,
    output logic                          A_SNaN_o,
    output logic                          B_Sign_o,
    output logic [PARM_EXP-1:0]           B_Exp_raw_o,
    output logic [PARM_EXP-1:0]           B_Exp_eff_o,
    output logic [PARM_MANT:0]            B_Mant_o,
    output logic                          B_DeN_o,
    output logic                          B_Zero_o,
    output logic                          B_Inf_o,
    output logic                          B_NaN_o,
    output logic                          B_SNaN_o,
    output logic                          C_Sign_o,
    output logic [PARM_EXP-1:0]           C_Exp_raw_o,
    output logic [PARM_EXP-1:0]           C_Exp_eff_o,
    output logic [PARM_MANT:0]            C_Mant_o,
    output logic                          C_DeN_o,
    output logic                          C_Zero_o,
    output logic                          C_Inf_o,
    output logic                          C_NaN_o,
    output logic                          C_SNaN_o,
    output logic                          Sub_Sign_o,
    output logic [PARM_RM-1:0]            Rounding_mode_o
);

    localparam int c_W = PARM_EXP + PARM_MANT + 1;

    logic                 r_s1_v;
    logic [c_W-1:0]       r_s1_op [3];
    logic                 r_s1_neg;
    logic [PARM_RM-1:0]   r_s1_rm;

    logic                 r_s2_v;
    logic                 r_s2_sign [3];
    logic [PARM_EXP-1:0]  r_s2_exp  [3];
    logic [PARM_EXP-1:0]  r_s2_eff  [3];
    logic [PARM_MANT:0]   r_s2_mant [3];
    logic                 r_s2_den  [3];
    logic                 r_s2_zero [3];
    logic                 r_s2_inf  [3];
    logic                 r_s2_nan  [3];
    logic                 r_s2_snan [3];
    logic                 r_s2_sub;
    logic [PARM_RM-1:0]   r_s2_rm;

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_in_hs;
    logic                 w_sign [3];
    logic [PARM_EXP-1:0]  w_exp  [3];
    logic [PARM_EXP-1:0]  w_eff  [3];
    logic [PARM_MANT:0]   w_mant [3];
    logic                 w_den  [3];
    logic                 w_zero [3];
    logic                 w_inf  [3];
    logic                 w_nan  [3];
    logic                 w_snan [3];
    logic                 w_sub;

    assign w_s2_adv   = ~r_s2_v | Out_ready_i;
    assign w_s1_adv   = r_s1_v & w_s2_adv;
    assign In_ready_o = ~r_s1_v | w_s1_adv;
    assign w_in_hs    = In_valid_i & In_ready_o;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dec
            logic [PARM_EXP-1:0]  w_e;
            logic [PARM_MANT-1:0] w_f;
            logic                 w_e_zero;
            logic                 w_e_ones;
            logic                 w_f_zero;

            assign w_e      = r_s1_op[gi][c_W-2:PARM_MANT];
            assign w_f      = r_s1_op[gi][PARM_MANT-1:0];
            assign w_e_zero = (w_e == '0);
            assign w_e_ones = &w_e;
            assign w_f_zero = (w_f == '0);

            assign w_sign[gi] = r_s1_op[gi][c_W-1];
            assign w_exp[gi]  = w_e;
            assign w_eff[gi]  = w_e_zero ? {{(PARM_EXP-1){1'b0}}, 1'b1} : w_e;
            // Hidden bit is set for every nonzero exponent, Inf/NaN included.
            assign w_mant[gi] = {~w_e_zero, w_f};
            assign w_zero[gi] = w_e_zero & w_f_zero;
            assign w_den[gi]  = w_e_zero & ~w_f_zero;
            assign w_inf[gi]  = w_e_ones & w_f_zero;
            assign w_nan[gi]  = w_e_ones & ~w_f_zero;
            assign w_snan[gi] = w_e_ones & ~w_f_zero & ~w_f[PARM_MANT-1];
        end
    endgenerate

    assign w_sub = r_s1_op[0][c_W-1] ^ r_s1_op[1][c_W-1] ^ r_s1_op[2][c_W-1] ^ r_s1_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_neg <= 1'b0;
            r_s1_rm  <= '0;
            for (int i = 0; i < 3; i++) r_s1_op[i] <= '0;
        end else if (w_in_hs) begin
            r_s1_v     <= 1'b1;
            r_s1_op[0] <= A_i;
            r_s1_op[1] <= B_i;
            r_s1_op[2] <= C_i;
            r_s1_neg   <= Negate_i;
            r_s1_rm    <= Rounding_mode_i;
        end else if (w_s1_adv) begin
            r_s1_v <= 1'b0;
        end
    end

    // Data registers only move on a real transfer; an emptying stage keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v   <= 1'b0;
            r_s2_sub <= 1'b0;
            r_s2_rm  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_s2_sign[i] <= 1'b0;
                r_s2_exp[i]  <= '0;
                r_s2_eff[i]  <= '0;
                r_s2_mant[i] <= '0;
                r_s2_den[i]  <= 1'b0;
                r_s2_zero[i] <= 1'b0;
                r_s2_inf[i]  <= 1'b0;
                r_s2_nan[i]  <= 1'b0;
                r_s2_snan[i] <= 1'b0;
            end
        end else if (w_s1_adv) begin
            r_s2_v   <= 1'b1;
            r_s2_sub <= w_sub;
            r_s2_rm  <= r_s1_rm;
            for (int i = 0; i < 3; i++) begin
                r_s2_sign[i] <= w_sign[i];
                r_s2_exp[i]  <= w_exp[i];
                r_s2_eff[i]  <= w_eff[i];
                r_s2_mant[i] <= w_mant[i];
                r_s2_den[i]  <= w_den[i];
                r_s2_zero[i] <= w_zero[i];
                r_s2_inf[i]  <= w_inf[i];
                r_s2_nan[i]  <= w_nan[i];
                r_s2_snan[i] <= w_snan[i];
            end
        end else if (w_s2_adv) begin
            r_s2_v <= 1'b0;
        end
    end

    assign Out_valid_o     = r_s2_v;
    assign Sub_Sign_o      = r_s2_sub;
    assign Rounding_mode_o = r_s2_rm;

    assign A_Sign_o    = r_s2_sign[0];
    assign A_Exp_raw_o = r_s2_exp[0];
    assign A_Exp_eff_o = r_s2_eff[0];
    assign A_Mant_o    = r_s2_mant[0];
    assign A_DeN_o     = r_s2_den[0];
    assign A_Zero_o    = r_s2_zero[0];
    assign A_Inf_o     = r_s2_inf[0];
    assign A_NaN_o     = r_s2_nan[0];
    assign A_SNaN_o    = r_s2_snan[0];

    assign B_Sign_o    = r_s2_sign[1];
    assign B_Exp_raw_o = r_s2_exp[1];
    assign B_Exp_eff_o = r_s2_eff[1];
    assign B_Mant_o    = r_s2_mant[1];
    assign B_DeN_o     = r_s2_den[1];
    assign B_Zero_o    = r_s2_zero[1];
    assign B_Inf_o     = r_s2_inf[1];
    assign B_NaN_o     = r_s2_nan[1];
    assign B_SNaN_o    = r_s2_snan[1];

    assign C_Sign_o    = r_s2_sign[2];
    assign C_Exp_raw_o = r_s2_exp[2];
    assign C_Exp_eff_o = r_s2_eff[2];
    assign C_Mant_o    = r_s2_mant[2];
    assign C_DeN_o     = r_s2_den[2];
    assign C_Zero_o    = r_s2_zero[2];
    assign C_Inf_o     = r_s2_inf[2];
    assign C_NaN_o     = r_s2_nan[2];
    assign C_SNaN_o    = r_s2_snan[2];

endmodule

`default_nettype wire

// File: tb/tb_fma_operand_unpack.sv
// ============================================================================
// Module   : tb_fma_operand_unpack
// Brief    : Randomised and directed bench for fma_operand_unpack against a
//            queue-based transaction model with arithmetic field decoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fma_operand_unpack;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        neg;
        logic [2:0]  rm;
        int          acc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] A_i = '0, B_i = '0, C_i = '0;
    logic        Negate_i = 1'b0;
    logic [2:0]  Rounding_mode_i = '0;
    logic        In_valid_i = 1'b0;
    logic        In_ready_o;
    logic        Out_valid_o;
    logic        Out_ready_i = 1'b0;
    logic        A_Sign_o, B_Sign_o, C_Sign_o;
    logic [7:0]  A_Exp_raw_o, B_Exp_raw_o, C_Exp_raw_o;
    logic [7:0]  A_Exp_eff_o, B_Exp_eff_o, C_Exp_eff_o;
    logic [23:0] A_Mant_o, B_Mant_o, C_Mant_o;
    logic        A_DeN_o, A_Zero_o, A_Inf_o, A_NaN_o, A_SNaN_o;
    logic        B_DeN_o, B_Zero_o, B_Inf_o, B_NaN_o, B_SNaN_o;
    logic        C_DeN_o, C_Zero_o, C_Inf_o, C_NaN_o, C_SNaN_o;
    logic        Sub_Sign_o;
    logic [2:0]  Rounding_mode_o;

    fma_operand_unpack #(.PARM_EXP(8), .PARM_MANT(23), .PARM_RM(3)) u_dut (
        .clk(clk), .rst(rst),
        .A_i(A_i), .B_i(B_i), .C_i(C_i),
        .Negate_i(Negate_i), .Rounding_mode_i(Rounding_mode_i),
        .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
        .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
        .A_Sign_o(A_Sign_o), .A_Exp_raw_o(A_Exp_raw_o), .A_Exp_eff_o(A_Exp_eff_o), .A_Mant_o(A_Mant_o),
        .A_DeN_o(A_DeN_o), .A_Zero_o(A_Zero_o), .A_Inf_o(A_Inf_o), .A_NaN_o(A_NaN_o), .A_SNaN_o(A_SNaN_o),
        .B_Sign_o(B_Sign_o), .B_Exp_raw_o(B_Exp_raw_o), .B_Exp_eff_o(B_Exp_eff_o), .B_Mant_o(B_Mant_o),
        .B_DeN_o(B_DeN_o), .B_Zero_o(B_Zero_o), .B_Inf_o(B_Inf_o), .B_NaN_o(B_NaN_o), .B_SNaN_o(B_SNaN_o),
        .C_Sign_o(C_Sign_o), .C_Exp_raw_o(C_Exp_raw_o), .C_Exp_eff_o(C_Exp_eff_o), .C_Mant_o(C_Mant_o),
        .C_DeN_o(C_DeN_o), .C_Zero_o(C_Zero_o), .C_Inf_o(C_Inf_o), .C_NaN_o(C_NaN_o), .C_SNaN_o(C_SNaN_o),
        .Sub_Sign_o(Sub_Sign_o), .Rounding_mode_o(Rounding_mode_o)
    );

    always #5 clk = ~clk;

    logic [45:0] w_dA, w_dB, w_dC;
    assign w_dA = {A_Sign_o, A_Exp_raw_o, A_Exp_eff_o, A_Mant_o, A_DeN_o, A_Zero_o, A_Inf_o, A_NaN_o, A_SNaN_o};
    assign w_dB = {B_Sign_o, B_Exp_raw_o, B_Exp_eff_o, B_Mant_o, B_DeN_o, B_Zero_o, B_Inf_o, B_NaN_o, B_SNaN_o};
    assign w_dC = {C_Sign_o, C_Exp_raw_o, C_Exp_eff_o, C_Mant_o, C_DeN_o, C_Zero_o, C_Inf_o, C_NaN_o, C_SNaN_o};

    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;
    bit    zero_pend = 1'b0;
    item_t q[$];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference decode: {sign, raw exp, eff exp, mant, den, zero, inf, nan, snan}.
    function automatic logic [45:0] ref_dec(input logic [31:0] x);
        int unsigned e, f, mant, eff;
        bit zero, den, inf, nan, snan;
        e    = (x / 32'h0080_0000) % 256;
        f    = x % 32'h0080_0000;
        zero = (e == 0) && (f == 0);
        den  = (e == 0) && (f != 0);
        inf  = (e == 255) && (f == 0);
        nan  = (e == 255) && (f != 0);
        snan = nan && (f < 32'h0040_0000);
        mant = (e != 0) ? f + 32'h0080_0000 : f;
        eff  = (e == 0) ? 1 : e;
        return {x[31], e[7:0], eff[7:0], mant[23:0], den, zero, inf, nan, snan};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        s = 1'($urandom);
        case ($urandom_range(0, 4))
            0: e = 8'h00;
            1: e = 8'hFF;
            2: e = 8'h01;
            3: e = 8'hFE;
            default: e = 8'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0: f = 23'h0;
            1: f = 23'h1;
            2: f = 23'h40_0000;
            3: f = 23'h3F_FFFF;
            4: f = 23'h7F_FFFF;
            default: f = 23'($urandom);
        endcase
        return {s, e, f};
    endfunction

    function automatic item_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                 input logic neg, input logic [2:0] rm);
        item_t it;
        it.a = a; it.b = b; it.c = c; it.neg = neg; it.rm = rm; it.acc = 0;
        return it;
    endfunction

    function automatic item_t rnd_item();
        return mk(rnd_op(), rnd_op(), rnd_op(), 1'($urandom), 3'($urandom));
    endfunction

    // One clock cycle: drive, check at the falling edge, then advance the model.
    task automatic run_cycle(input logic v, input item_t it, input logic ordy, input logic rs,
                             output logic accepted);
        logic exp_v, exp_r, out_hs, in_hs;
        item_t nw;
        rst = rs; In_valid_i = v; Out_ready_i = ordy;
        A_i = it.a; B_i = it.b; C_i = it.c; Negate_i = it.neg; Rounding_mode_i = it.rm;
        accepted = 1'b0; out_hs = 1'b0; in_hs = 1'b0;
        @(negedge clk);
        if (!rs) begin
            exp_v = (q.size() > 0) && (q[0].acc <= cyc - 1);
            exp_r = (q.size() < 2) || ordy;
            chk_eq("in_ready", 64'(In_ready_o), 64'(exp_r));
            chk_eq("out_valid", 64'(Out_valid_o), 64'(exp_v));
            if (zero_pend) begin
                chk_eq("rst_A", 64'(w_dA), 64'h0);
                chk_eq("rst_B", 64'(w_dB), 64'h0);
                chk_eq("rst_C", 64'(w_dC), 64'h0);
                chk_eq("rst_misc", 64'({Sub_Sign_o, Rounding_mode_o}), 64'h0);
            end
            if (exp_v) begin
                chk_eq("dec_A", 64'(w_dA), 64'(ref_dec(q[0].a)));
                chk_eq("dec_B", 64'(w_dB), 64'(ref_dec(q[0].b)));
                chk_eq("dec_C", 64'(w_dC), 64'(ref_dec(q[0].c)));
                chk_eq("sub_sign", 64'(Sub_Sign_o), 64'(q[0].a[31] ^ q[0].b[31] ^ q[0].c[31] ^ q[0].neg));
                chk_eq("rmode", 64'(Rounding_mode_o), 64'(q[0].rm));
            end
            out_hs = exp_v && ordy;
            in_hs  = v && exp_r;
        end
        @(posedge clk);
        cyc++;
        if (rs) begin
            q.delete();
            zero_pend = 1'b1;
        end else begin
            zero_pend = 1'b0;
            if (out_hs) void'(q.pop_front());
            if (in_hs) begin
                nw = it;
                nw.acc = cyc;
                q.push_back(nw);
                accepted = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        item_t dir [4];
        item_t idle;
        logic  acc;
        int    k;

        idle = mk(32'h0, 32'h0, 32'h0, 1'b0, 3'h0);
        run_cycle(1'b0, idle, 1'b0, 1'b1, acc);
        run_cycle(1'b1, rnd_item(), 1'b1, 1'b1, acc);

        // Directed operand cases: normal values, denormal/zero/inf, quiet vs signalling NaN.
        dir[0] = mk(32'h3F80_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 3'h0);
        dir[1] = mk(32'h0000_0001, 32'h8000_0000, 32'h7F80_0000, 1'b0, 3'h1);
        dir[2] = mk(32'h7FC0_0000, 32'h7F80_0001, 32'hFF80_0000, 1'b1, 3'h7);
        dir[3] = mk(32'h007F_FFFF, 32'h7FFF_FFFF, 32'hFFBF_FFFF, 1'b1, 3'h5);
        for (int i = 0; i < 4; i++) run_cycle(1'b1, dir[i], 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, idle, 1'b1, 1'b0, acc);
        chk_eq("drain", 64'(q.size()), 64'h0);

        // Back-to-back with the sink stalled for five cycles.
        for (int i = 0; i < 4; i++) dir[i] = rnd_item();
        k = 0;
        for (int t = 0; t < 14; t++) begin
            run_cycle(k < 4, (k < 4) ? dir[k] : idle, !(t >= 1 && t <= 5), 1'b0, acc);
            if (acc) k++;
        end
        chk_eq("stall_all_in", 64'(k), 64'h4);
        chk_eq("stall_drain", 64'(q.size()), 64'h0);

        // Two items in flight, then a one-cycle reset with a competing input.
        run_cycle(1'b1, rnd_item(), 1'b0, 1'b0, acc);
        run_cycle(1'b1, rnd_item(), 1'b0, 1'b0, acc);
        run_cycle(1'b1, rnd_item(), 1'b1, 1'b1, acc);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, idle, 1'b1, 1'b0, acc);

        for (int t = 0; t < 3000; t++) begin
            run_cycle($urandom_range(0, 3) != 0, rnd_item(), $urandom_range(0, 9) < 7,
                      $urandom_range(0, 99) == 0, acc);
        end
        for (int i = 0; i < 4; i++) run_cycle(1'b0, idle, 1'b1, 1'b0, acc);
        chk_eq("final_drain", 64'(q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
